// File: rtl/test_run_sequencer_if.sv
// Config/status bundle between the config register file (master) and the
// test run sequencer (slave), including the per-port generator controls.
interface test_run_sequencer_if #(
    parameter int unsigned NUM_PORTS = 4
);
    logic [12:0]          cfg_duration;
    logic                 cfg_start;
    logic                 cfg_abort;
    logic [NUM_PORTS-1:0] port_enable;
    logic                 busy;
    logic [12:0]          actual_duration;
    logic                 stats_clear;
    logic [NUM_PORTS-1:0] gen_enable;
    logic                 done;

    modport master (
        output cfg_duration, cfg_start, cfg_abort, port_enable,
        input  busy, actual_duration, stats_clear, gen_enable, done
    );

    modport slave (
        input  cfg_duration, cfg_start, cfg_abort, port_enable,
        output busy, actual_duration, stats_clear, gen_enable, done
    );
endinterface

// File: rtl/test_run_sequencer.sv
// Sequences one throughput test: clear stats, run enabled generators for the
// programmed number of ms, drain for WAIT_MS ms, then report and pulse done.
module test_run_sequencer #(
    parameter int unsigned NUM_PORTS   = 4,
    parameter int unsigned CLK_FREQ_HZ = 125000000,
    parameter int unsigned WAIT_MS     = 100
) (
    input logic             clk,
    input logic             reset,
    test_run_sequencer_if.slave bus
);
    localparam int unsigned CYC_PER_MS = CLK_FREQ_HZ / 1000;
    localparam int unsigned PW         = $clog2(CYC_PER_MS);
    localparam int unsigned WW         = (WAIT_MS > 0) ? $clog2(WAIT_MS + 1) : 1;
    localparam int unsigned DW         = 13;

    localparam logic [PW-1:0] PRESC_MAX = PW'(CYC_PER_MS - 1);
    localparam logic [DW-1:0] MS_MAX    = '1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]           state_q,  state_d;
    logic [DW-1:0]        dur_q,    dur_d;
    logic [NUM_PORTS-1:0] en_q,     en_d;
    logic [PW-1:0]        presc_q,  presc_d;
    logic [DW-1:0]        ms_cnt_q, ms_cnt_d;
    logic [WW-1:0]        wait_q,   wait_d;
    logic                 busy_q,   busy_d;
    logic [DW-1:0]        actual_q, actual_d;
    logic                 clear_q,  clear_d;
    logic [NUM_PORTS-1:0] gen_q,    gen_d;
    logic                 done_q,   done_d;

    logic          ms_tick_c;
    logic [DW-1:0] ms_inc_c;

    assign ms_tick_c = (presc_q == PRESC_MAX);
    assign ms_inc_c  = (ms_cnt_q == MS_MAX) ? MS_MAX : ms_cnt_q + DW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            dur_q    <= '0;
            en_q     <= '0;
            presc_q  <= '0;
            ms_cnt_q <= '0;
            wait_q   <= '0;
            busy_q   <= 1'b0;
            actual_q <= '0;
            clear_q  <= 1'b0;
            gen_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dur_q    <= dur_d;
            en_q     <= en_d;
            presc_q  <= presc_d;
            ms_cnt_q <= ms_cnt_d;
            wait_q   <= wait_d;
            busy_q   <= busy_d;
            actual_q <= actual_d;
            clear_q  <= clear_d;
            gen_q    <= gen_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dur_d    = dur_q;
        en_d     = en_q;
        presc_d  = presc_q;
        ms_cnt_d = ms_cnt_q;
        wait_d   = wait_q;
        busy_d   = busy_q;
        actual_d = actual_q;
        clear_d  = 1'b0;
        gen_d    = gen_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cfg_start) begin
                    dur_d   = bus.cfg_duration;
                    en_d    = bus.port_enable;
                    busy_d  = 1'b1;
                    clear_d = 1'b1;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                presc_d  = '0;
                ms_cnt_d = '0;
                wait_d   = '0;
                // A zero-length test is a RUN that ends before it starts.
                if (dur_q == '0) begin
                    actual_d = '0;
                    state_d  = ST_DRAIN;
                end else begin
                    gen_d   = en_q;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                presc_d = ms_tick_c ? '0 : presc_q + PW'(1);
                if (ms_tick_c) begin
                    ms_cnt_d = ms_inc_c;
                end
                if ((ms_tick_c && ((14'(ms_cnt_q) + 14'd1) == 14'(dur_q))) || bus.cfg_abort) begin
                    actual_d = ms_tick_c ? ms_inc_c : ms_cnt_q;
                    gen_d    = '0;
                    presc_d  = '0;
                    wait_d   = '0;
                    state_d  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (WAIT_MS == 0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    presc_d = ms_tick_c ? '0 : presc_q + PW'(1);
                    if (ms_tick_c) begin
                        wait_d = wait_q + WW'(1);
                        if ((32'(wait_q) + 32'd1) == 32'(WAIT_MS)) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.busy            = busy_q;
    assign bus.actual_duration = actual_q;
    assign bus.stats_clear     = clear_q;
    assign bus.gen_enable      = gen_q;
    assign bus.done            = done_q;
endmodule

// File: tb/tb_test_run_sequencer.sv
// Self-checking bench for test_run_sequencer: directed scenarios plus random
// runs checked against a cycle-count model of one test sequence.
module tb_test_run_sequencer;
    localparam int unsigned NP    = 4;
    localparam int unsigned CYC   = 10;
    localparam int unsigned WAITM = 2;
    localparam int unsigned CYC6  = 2;

    typedef struct {
        int clear_cnt;
        int gen_cnt;
        int bad_gen;
        int busy_cnt;
        int done_cnt;
        int busy_at_done;
        int actual;
        int extra;
        int timeout;
    } meas_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    test_run_sequencer_if #(.NUM_PORTS(NP)) bus ();
    test_run_sequencer_if #(.NUM_PORTS(NP)) bus6 ();

    test_run_sequencer #(.NUM_PORTS(NP), .CLK_FREQ_HZ(CYC * 1000), .WAIT_MS(WAITM)) u_dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );
    test_run_sequencer #(.NUM_PORTS(NP), .CLK_FREQ_HZ(CYC6 * 1000), .WAIT_MS(WAITM)) u_dut6 (
        .clk(clk), .reset(reset), .bus(bus6.slave)
    );

    // One test as seen from outside: 1 clear cycle, generator cycles, drain.
    function automatic void model(input int dur, input int abort_at,
                                  output int gen, output int actual, output int busy_len);
        int run_len;
        run_len = dur * CYC;
        gen = (abort_at > 0 && abort_at < run_len) ? abort_at : run_len;
        actual = gen / CYC;
        busy_len = 1 + gen + WAITM * CYC;
    endfunction

    task automatic run_seq(input int dur, input logic [NP-1:0] en, input int abort_at,
                           input bit spam, input bit abort_with_start, output meas_t m);
        m = '{default: 0};
        bus.cfg_duration = 13'(dur);
        bus.port_enable  = en;
        bus.cfg_start    = 1'b1;
        bus.cfg_abort    = abort_with_start;
        @(posedge clk); #1;
        bus.cfg_start = spam;
        bus.cfg_abort = 1'b0;
        m.timeout = 1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (bus.stats_clear) m.clear_cnt++;
            if (bus.busy) m.busy_cnt++;
            if (bus.gen_enable != '0) begin
                m.gen_cnt++;
                if (bus.gen_enable !== en) m.bad_gen++;
            end
            if (bus.done) begin
                m.done_cnt++;
                m.busy_at_done = int'(bus.busy);
                m.actual = int'(bus.actual_duration);
                m.timeout = 0;
                break;
            end
            bus.cfg_abort = (bus.gen_enable != '0) && (m.gen_cnt == abort_at);
            if (spam) begin
                bus.cfg_start    = bus.busy;
                bus.cfg_duration = 13'($urandom);
                bus.port_enable  = NP'($urandom);
            end
            @(posedge clk); #1;
        end
        bus.cfg_start = 1'b0;
        bus.cfg_abort = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy || bus.stats_clear || bus.gen_enable != '0) m.extra++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.stats_clear !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: busy=%b done=%b clear=%b, required 0 0 0", bus.busy, bus.done, bus.stats_clear);
        end
        checks++;
        if (bus.gen_enable !== '0 || bus.actual_duration !== '0) begin
            errors++; $display("FAIL reset_data: gen=%b actual=%0d, required 0 0", bus.gen_enable, bus.actual_duration);
        end
    endtask

    task automatic test_basic();
        meas_t m; int g, a, b;
        model(3, 0, g, a, b);
        run_seq(3, 4'b0101, 0, 1'b0, 1'b0, m);
        checks++;
        if (m.timeout != 0 || m.done_cnt != 1) begin errors++; $display("FAIL basic_done: timeout=%0d done=%0d, required 0 1", m.timeout, m.done_cnt); end
        checks++;
        if (m.clear_cnt != 1) begin errors++; $display("FAIL basic_clear: %0d cycles, required 1", m.clear_cnt); end
        checks++;
        if (m.gen_cnt != g || m.bad_gen != 0) begin errors++; $display("FAIL basic_gen: %0d cycles bad=%0d, required %0d bad=0", m.gen_cnt, m.bad_gen, g); end
        checks++;
        if (m.busy_cnt != b || m.busy_at_done != 0) begin errors++; $display("FAIL basic_busy: %0d cycles at_done=%0d, required %0d 0", m.busy_cnt, m.busy_at_done, b); end
        checks++;
        if (m.actual != a) begin errors++; $display("FAIL basic_actual: %0d, required %0d", m.actual, a); end
        checks++;
        if (m.extra != 0) begin errors++; $display("FAIL basic_after: %0d active cycles after done, required 0", m.extra); end
    endtask

    task automatic test_zero_duration();
        meas_t m; int g, a, b;
        model(0, 0, g, a, b);
        run_seq(0, 4'b1111, 0, 1'b0, 1'b0, m);
        checks++;
        if (m.timeout != 0 || m.done_cnt != 1 || m.clear_cnt != 1) begin
            errors++; $display("FAIL zero_done: timeout=%0d done=%0d clear=%0d, required 0 1 1", m.timeout, m.done_cnt, m.clear_cnt);
        end
        checks++;
        if (m.gen_cnt != 0 || m.busy_cnt != b) begin errors++; $display("FAIL zero_timing: gen=%0d busy=%0d, required 0 %0d", m.gen_cnt, m.busy_cnt, b); end
        checks++;
        if (m.actual != a) begin errors++; $display("FAIL zero_actual: %0d, required %0d", m.actual, a); end
    endtask

    task automatic test_abort();
        meas_t m; int g, a, b;
        model(100, 25, g, a, b);
        run_seq(100, 4'b1010, 25, 1'b0, 1'b0, m);
        checks++;
        if (m.timeout != 0 || m.done_cnt != 1) begin errors++; $display("FAIL abort_done: timeout=%0d done=%0d, required 0 1", m.timeout, m.done_cnt); end
        checks++;
        if (m.gen_cnt != g || m.busy_cnt != b) begin errors++; $display("FAIL abort_timing: gen=%0d busy=%0d, required %0d %0d", m.gen_cnt, m.busy_cnt, g, b); end
        checks++;
        if (m.actual != a) begin errors++; $display("FAIL abort_actual: %0d, required %0d", m.actual, a); end
    endtask

    task automatic test_back_to_back();
        meas_t m; int g, a, b;
        model(2, 0, g, a, b);
        run_seq(2, 4'b0011, 0, 1'b1, 1'b0, m);
        checks++;
        if (m.timeout != 0 || m.done_cnt != 1 || m.clear_cnt != 1 || m.extra != 0) begin
            errors++; $display("FAIL b2b_single: timeout=%0d done=%0d clear=%0d extra=%0d, required 0 1 1 0", m.timeout, m.done_cnt, m.clear_cnt, m.extra);
        end
        checks++;
        if (m.gen_cnt != g || m.bad_gen != 0 || m.busy_cnt != b) begin
            errors++; $display("FAIL b2b_timing: gen=%0d bad=%0d busy=%0d, required %0d 0 %0d", m.gen_cnt, m.bad_gen, m.busy_cnt, g, b);
        end
        checks++;
        if (m.actual != a) begin errors++; $display("FAIL b2b_actual: %0d, required %0d", m.actual, a); end
        model(1, 0, g, a, b);
        run_seq(1, 4'b1100, 0, 1'b0, 1'b1, m);
        checks++;
        if (m.gen_cnt != g || m.actual != a || m.done_cnt != 1) begin
            errors++; $display("FAIL b2b_later: gen=%0d actual=%0d done=%0d, required %0d %0d 1", m.gen_cnt, m.actual, m.done_cnt, g, a);
        end
    endtask

    task automatic test_reset_mid_run();
        meas_t m; int g, a, b; int run_cycles; int seen_done;
        run_cycles = 0;
        seen_done = 0;
        bus.cfg_duration = 13'd3;
        bus.port_enable  = 4'b1111;
        bus.cfg_start    = 1'b1;
        @(posedge clk); #1;
        bus.cfg_start = 1'b0;
        for (int cyc = 0; cyc < 40 && run_cycles < 5; cyc++) begin
            if (bus.gen_enable != '0) run_cycles++;
            if (run_cycles < 5) begin @(posedge clk); #1; end
        end
        checks++;
        if (run_cycles != 5) begin errors++; $display("FAIL rst_reach_run: %0d run cycles, required 5", run_cycles); end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.gen_enable !== '0 || bus.busy !== 1'b0 || bus.actual_duration !== '0) begin
            errors++; $display("FAIL rst_immediate: gen=%b busy=%b actual=%0d, required 0 0 0", bus.gen_enable, bus.busy, bus.actual_duration);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.done) seen_done++;
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin errors++; $display("FAIL rst_no_done: %0d done/busy cycles, required 0", seen_done); end
        model(1, 0, g, a, b);
        run_seq(1, 4'b0110, 0, 1'b0, 1'b0, m);
        checks++;
        if (m.gen_cnt != g || m.busy_cnt != b || m.actual != a || m.done_cnt != 1) begin
            errors++; $display("FAIL rst_after: gen=%0d busy=%0d actual=%0d done=%0d, required %0d %0d %0d 1", m.gen_cnt, m.busy_cnt, m.actual, m.done_cnt, g, b, a);
        end
    endtask

    task automatic test_random();
        meas_t m; int g, a, b; int dur; int ab; logic [NP-1:0] en;
        for (int t = 0; t < 8; t++) begin
            dur = int'($urandom_range(0, 6));
            en  = NP'($urandom_range(1, 15));
            ab  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 70)) : 0;
            model(dur, ab, g, a, b);
            run_seq(dur, en, ab, 1'b0, 1'b0, m);
            checks++;
            if (m.gen_cnt != g || m.bad_gen != 0 || m.busy_cnt != b || m.actual != a || m.done_cnt != 1 || m.clear_cnt != 1) begin
                errors++;
                $display("FAIL rand_%0d dur=%0d abort=%0d: gen=%0d bad=%0d busy=%0d actual=%0d done=%0d clear=%0d, required %0d 0 %0d %0d 1 1",
                         t, dur, ab, m.gen_cnt, m.bad_gen, m.busy_cnt, m.actual, m.done_cnt, m.clear_cnt, g, b, a);
            end
        end
    endtask

    task automatic test_max_duration();
        int gen_cnt; int busy_cnt; int got_done; int actual;
        gen_cnt = 0; busy_cnt = 0; got_done = 0; actual = 0;
        bus6.cfg_duration = 13'd8191;
        bus6.port_enable  = 4'b1001;
        bus6.cfg_start    = 1'b1;
        @(posedge clk); #1;
        bus6.cfg_start = 1'b0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (bus6.done) begin
                got_done = 1;
                actual = int'(bus6.actual_duration);
                break;
            end
            if (bus6.busy) busy_cnt++;
            if (bus6.gen_enable != '0) gen_cnt++;
            @(posedge clk); #1;
        end
        checks++;
        if (got_done != 1) begin errors++; $display("FAIL max_done: done=%0d, required 1", got_done); end
        checks++;
        if (gen_cnt != 8191 * CYC6 || busy_cnt != 1 + 8191 * CYC6 + WAITM * CYC6) begin
            errors++; $display("FAIL max_timing: gen=%0d busy=%0d, required %0d %0d", gen_cnt, busy_cnt, 8191 * CYC6, 1 + 8191 * CYC6 + WAITM * CYC6);
        end
        checks++;
        if (actual != 8191) begin errors++; $display("FAIL max_actual: %0d, required 8191", actual); end
    endtask

    initial begin
        bus.cfg_duration  = '0; bus.cfg_start  = 1'b0; bus.cfg_abort  = 1'b0; bus.port_enable  = '0;
        bus6.cfg_duration = '0; bus6.cfg_start = 1'b0; bus6.cfg_abort = 1'b0; bus6.port_enable = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        test_basic();
        test_zero_duration();
        test_abort();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        test_max_duration();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
